// File: rtl/uart_lite_target.sv
// FIFO-less 16550-subset UART target: register bus, 16x-oversampled 8N1 TX/RX
// and a level interrupt.
module uart_lite_target #(
  parameter logic [15:0] DIV_RESET   = 16'd0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       sin,
  output logic       sout
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic       wr_q, rd_q;
  logic [7:0] dll, dlm, lcr, scr, rbr, thr;
  logic [1:0] ier;
  logic       loopback, dr, oe, fe, thre, temt;
  logic [15:0] baud_cnt;
  logic [7:0] rdata;

  logic dlab, wr_edge, rd_act, rd_edge, thr_wr, div_wr, rbr_rd, lsr_rd, tick;
  logic [15:0] divisor;

  assign dlab    = lcr[7];
  assign wr_edge = cs & wr & ~wr_q;
  assign rd_act  = cs & rd;
  assign rd_edge = rd_act & ~rd_q;
  assign thr_wr  = wr_edge && (a == 3'd0) && !dlab;
  assign div_wr  = wr_edge && dlab && ((a == 3'd0) || (a == 3'd1));
  assign rbr_rd  = rd_edge && (a == 3'd0) && !dlab;
  assign lsr_rd  = rd_edge && (a == 3'd5);
  assign divisor = {dlm, dll};
  assign tick    = (divisor != 16'd0) && (baud_cnt == divisor - 16'd1);

  // ---------------- TX ----------------
  state_e     tx_state_q, tx_state_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bcnt_q, tx_bcnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_load, tx_done, tx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_load    = 1'b0;
    tx_done    = 1'b0;
    if (tick) begin
      unique case (tx_state_q)
        StIdle: begin
          if (!thre) begin
            tx_load    = 1'b1;
            tx_shift_d = thr;
            tx_tcnt_d  = 4'd0;
            tx_state_d = StStart;
          end
        end
        StStart: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_bcnt_d  = 3'd0;
            tx_state_d = StData;
          end
        end
        StData: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bcnt_d  = tx_bcnt_q + 3'd1;
            if (tx_bcnt_q == 3'd7) tx_state_d = StStop;
          end
        end
        StStop: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            // Back-to-back: a pending THR byte skips IDLE entirely.
            if (!thre) begin
              tx_load    = 1'b1;
              tx_shift_d = thr;
              tx_state_d = StStart;
            end else begin
              tx_done    = 1'b1;
              tx_state_d = StIdle;
            end
          end
        end
        default: tx_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= StIdle;
      tx_tcnt_q  <= 4'd0;
      tx_bcnt_q  <= 3'd0;
      tx_shift_q <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign tx_line = (tx_state_q == StStart) ? 1'b0 :
                   (tx_state_q == StData)  ? tx_shift_q[0] : 1'b1;
  assign sout    = loopback | tx_line;

  // ---------------- RX ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_in, rx_load, rx_ferr;
  state_e     rx_state_q, rx_state_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bcnt_q, rx_bcnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;

  assign rx_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (!rx_in) begin
          rx_tcnt_d  = 4'd0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d  = 4'd0;
            rx_bcnt_d  = 3'd0;
            rx_state_d = rx_in ? StIdle : StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_shift_d = {rx_in, rx_shift_q[7:1]};
            rx_bcnt_d  = rx_bcnt_q + 3'd1;
            if (rx_bcnt_q == 3'd7) rx_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd15) begin
            rx_load    = 1'b1;
            rx_ferr    = !rx_in;
            rx_state_d = StIdle;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= '1;
      rx_state_q <= StIdle;
      rx_tcnt_q  <= 4'd0;
      rx_bcnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], loopback ? tx_line : sin};
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      dll      <= DIV_RESET[7:0];
      dlm      <= DIV_RESET[15:8];
      lcr      <= 8'h00;
      scr      <= 8'h00;
      rbr      <= 8'h00;
      thr      <= 8'h00;
      ier      <= 2'b00;
      loopback <= 1'b0;
      dr       <= 1'b0;
      oe       <= 1'b0;
      fe       <= 1'b0;
      thre     <= 1'b1;
      temt     <= 1'b1;
      baud_cnt <= 16'd0;
      dout     <= 8'h00;
      irq      <= 1'b0;
    end else begin
      wr_q <= cs & wr;
      rd_q <= rd_act;
      if (div_wr || divisor == 16'd0 || tick) baud_cnt <= 16'd0;
      else                                    baud_cnt <= baud_cnt + 16'd1;

      if (wr_edge) begin
        case (a)
          3'd0: if (dlab) dll <= din; else thr <= din;
          3'd1: if (dlab) dlm <= din; else ier <= din[1:0];
          3'd3: lcr <= din;
          3'd4: loopback <= din[4];
          3'd7: scr <= din;
          default: ;
        endcase
      end

      if (tx_load) thre <= 1'b1;
      if (tx_done) temt <= 1'b1;
      if (thr_wr) begin
        thre <= 1'b0;
        temt <= 1'b0;
      end

      // Set-side updates follow the clears so a same-cycle event wins.
      if (rbr_rd) dr <= 1'b0;
      if (lsr_rd) begin
        oe <= 1'b0;
        fe <= 1'b0;
      end
      if (rx_load) begin
        rbr <= rx_shift_q;
        dr  <= 1'b1;
        if (dr && !rbr_rd) oe <= 1'b1;
        if (rx_ferr) fe <= 1'b1;
      end

      if (rd_act) dout <= rdata;
      irq <= (ier[0] & dr) | (ier[1] & thre);
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (a)
      3'd0: rdata = dlab ? dll : rbr;
      3'd1: rdata = dlab ? dlm : {6'b0, ier};
      3'd2: rdata = (ier[0] & dr) ? 8'h04 : (ier[1] & thre) ? 8'h02 : 8'h01;
      3'd3: rdata = lcr;
      3'd4: rdata = {3'b0, loopback, 4'b0};
      3'd5: rdata = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
      3'd7: rdata = scr;
      default: rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_lite_target.sv
// Directed bench for uart_lite_target: register map, TX framing, RX, overrun,
// framing error, loopback and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_lite_target;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0] a = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic       sin = 1'b1;
  logic       sout;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_lite_target dut (
    .clk  (clk),
    .rstn (rstn),
    .cs   (cs),
    .wr   (wr),
    .rd   (rd),
    .a    (a),
    .din  (din),
    .dout (dout),
    .irq  (irq),
    .sin  (sin),
    .sout (sout)
  );

  task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; a = addr; din = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [7:0] data);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; a = addr;
    @(negedge clk);
    data = dout;
    cs = 1'b0; rd = 1'b0;
  endtask

  // 8N1 at 16 clk/bit; a bad stop bit is held low for 12 cycles only.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
    @(negedge clk);
    sin = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sin = data[i];
      repeat (16) @(negedge clk);
    end
    sin = stop_ok;
    repeat (stop_ok ? 16 : 12) @(negedge clk);
    sin = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic set_div1();
    bus_write(3'd3, 8'h83);
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h00);
    bus_write(3'd3, 8'h03);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("FAIL reset_sout: got %b want 1", sout); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    rstn = 1'b1;
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h60) begin n_fail++; $display("FAIL reset_lsr: got %h want 60", v); end
    bus_read(3'd2, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL reset_iir: got %h want 01", v); end
    bus_read(3'd3, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_lcr: got %h want 00", v); end
  endtask

  task automatic test_regs();
    logic [7:0] v;
    bus_write(3'd7, 8'hA5);
    bus_read(3'd7, v);
    n_cmp++; if (v !== 8'hA5) begin n_fail++; $display("FAIL scr_rw: got %h want a5", v); end
    // Held strobe must commit only the first cycle's data.
    @(negedge clk); cs = 1'b1; wr = 1'b1; a = 3'd7; din = 8'h11;
    @(negedge clk); din = 8'h22;
    @(negedge clk); din = 8'h33;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    bus_read(3'd7, v);
    n_cmp++; if (v !== 8'h11) begin n_fail++; $display("FAIL held_write: got %h want 11", v); end
    bus_write(3'd1, 8'hFF);
    bus_read(3'd1, v);
    n_cmp++; if (v !== 8'h03) begin n_fail++; $display("FAIL ier_mask: got %h want 03", v); end
    bus_read(3'd2, v);
    n_cmp++; if (v !== 8'h02) begin n_fail++; $display("FAIL iir_thre: got %h want 02", v); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_thre: got %b want 1", irq); end
    bus_write(3'd1, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_off: got %b want 0", irq); end
    bus_read(3'd6, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL msr: got %h want 00", v); end
    bus_write(3'd4, 8'hFF);
    bus_read(3'd4, v);
    n_cmp++; if (v !== 8'h10) begin n_fail++; $display("FAIL mcr_mask: got %h want 10", v); end
    bus_write(3'd4, 8'h00);
    bus_write(3'd3, 8'h83);
    bus_write(3'd0, 8'h34);
    bus_write(3'd1, 8'h12);
    bus_read(3'd0, v);
    n_cmp++; if (v !== 8'h34) begin n_fail++; $display("FAIL dll_rw: got %h want 34", v); end
    bus_read(3'd1, v);
    n_cmp++; if (v !== 8'h12) begin n_fail++; $display("FAIL dlm_rw: got %h want 12", v); end
    bus_read(3'd3, v);
    n_cmp++; if (v !== 8'h83) begin n_fail++; $display("FAIL lcr_rw: got %h want 83", v); end
    bus_write(3'd3, 8'h03);
  endtask

  task automatic test_tx();
    logic [9:0] frame;
    logic [7:0] v;
    bit         seen;
    frame = {1'b1, 8'h55, 1'b0};
    set_div1();
    bus_write(3'd0, 8'h55);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sout === 1'b0) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL tx_start: got no start bit want start within 40 cycles"); end
    if (seen) begin
      for (int i = 0; i < 160; i++) begin
        if (i != 0) @(negedge clk);
        n_cmp++;
        if (sout !== frame[i/16]) begin
          n_fail++;
          $display("FAIL tx_bit cycle %0d: got %b want %b", i, sout, frame[i/16]);
        end
      end
      bus_read(3'd5, v);
      n_cmp++; if (v !== 8'h60) begin n_fail++; $display("FAIL tx_temt: got %h want 60", v); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    bit         seen;
    bus_write(3'd0, 8'h0F);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sout === 1'b0) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_start: got no start bit want start within 40 cycles"); end
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("FAIL mid_sout_async: got %b want 1", sout); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL mid_dout: got %h want 00", dout); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("FAIL mid_discard: got %b want 1", sout); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h60) begin n_fail++; $display("FAIL mid_lsr: got %h want 60", v); end
    set_div1();
  endtask

  task automatic test_rx();
    logic [7:0] v;
    send_frame(8'hA3, 1'b1);
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h61) begin n_fail++; $display("FAIL rx_dr: got %h want 61", v); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 8'hA3) begin n_fail++; $display("FAIL rx_rbr: got %h want a3", v); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h60) begin n_fail++; $display("FAIL rx_lsr_clr: got %h want 60", v); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h63) begin n_fail++; $display("FAIL oe_lsr: got %h want 63", v); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h61) begin n_fail++; $display("FAIL oe_clear: got %h want 61", v); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 8'h22) begin n_fail++; $display("FAIL oe_rbr: got %h want 22", v); end
  endtask

  task automatic test_framing();
    logic [7:0] v;
    send_frame(8'h5A, 1'b0);
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h69) begin n_fail++; $display("FAIL fe_lsr: got %h want 69", v); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h61) begin n_fail++; $display("FAIL fe_clear: got %h want 61", v); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 8'h5A) begin n_fail++; $display("FAIL fe_rbr: got %h want 5a", v); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 8'h60) begin n_fail++; $display("FAIL fe_idle: got %h want 60", v); end
  endtask

  task automatic test_loopback();
    logic [7:0] v;
    bit         low_seen;
    bit         got_irq;
    int         cycles;
    bus_write(3'd4, 8'h10);
    bus_write(3'd1, 8'h01);
    bus_write(3'd0, 8'h3C);
    low_seen = 1'b0;
    got_irq  = 1'b0;
    cycles   = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (sout !== 1'b1) low_seen = 1'b1;
      if (irq === 1'b1) begin got_irq = 1'b1; cycles = i; break; end
    end
    n_cmp++; if (low_seen) begin n_fail++; $display("FAIL lb_sout: got low want steady 1"); end
    n_cmp++; if (!got_irq) begin n_fail++; $display("FAIL lb_irq: got 0 after 400 cycles want 1"); end
    n_cmp++;
    if (got_irq && (cycles < 150 || cycles > 180)) begin
      n_fail++;
      $display("FAIL lb_latency: got %0d cycles want 150..180", cycles);
    end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 8'h3C) begin n_fail++; $display("FAIL lb_rbr: got %h want 3c", v); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lb_irq_clr: got %b want 0", irq); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_regs();
    test_tx();
    test_reset_mid_frame();
    test_rx();
    test_overrun();
    test_framing();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
